// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the CPU-side memory
// responder (NES work RAM model).
//   - mem_resp_state_t : responder FSM state encoding
//   - BYTE_W           : byte width, taken from the BYTE macro
//   - MEM_RESP_WINDOW_BYTES : bytes returned per read window
//   - window_offset()  : byte index within the window served by a read state
`ifndef BYTE
`define BYTE 8
`endif

package mem_responder_pkg;

  localparam int BYTE_W                = `BYTE;
  localparam int MEM_RESP_WINDOW_BYTES = 3;

  // Legacy-compatible fixed encodings so the state values are stable in dumps.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    RD0  = 3'd2,
    RD1  = 3'd3,
    RD2  = 3'd4,
    WR   = 3'd5,
    DONE = 3'd6
  } mem_resp_state_t;

  // Byte index within the read window that a given state fetches.
  function automatic logic [1:0] window_offset(input mem_resp_state_t st);
    logic [1:0] off;
    case (st)
      RD1:     off = 2'd1;
      RD2:     off = 2'd2;
      default: off = 2'd0;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/mem_responder_byte_ram.sv
// mem_responder_byte_ram: byte-wide storage for the responder (the byte_ram
// sub-block). One synchronous write port and one asynchronous read port.
// Contents are deliberately not reset; they are undefined until written.
// Ports:
//   clk_i   - clock
//   we_i    - write enable, byte written at the rising edge
//   waddr_i - write byte address
//   wdata_i - write byte
//   raddr_i - read byte address (combinational read)
//   rdata_o - byte at raddr_i
module mem_responder_byte_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [BYTE_W-1:0]     wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [BYTE_W-1:0]     rdata_o
);

  logic [BYTE_W-1:0] mem_r [2**DEPTH_LOG2];

  // Single write port; no reset so the array maps onto RAM/LUT storage.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_r[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_r[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the CPU memory interface.
// Accepts one request at a time; a read returns a 3-byte instruction window
// mem[a], mem[a+1], mem[a+2] (byte index wraps within the RAM), a write
// stores one byte at mem[a]. The RAM is mirrored over the CPU address space
// by using only the low DEPTH_LOG2 address bits.
// Ports:
//   clk_i   - clock
//   rstn_i  - asynchronous active-low reset
//   req_i   - request strobe, only sampled while ready_o=1
//   we_i    - 1 = byte write, 0 = window read
//   addr_i  - CPU byte address
//   wdata_i - write byte
//   ready_o - idle; a request is accepted this cycle if req_i=1
//   valid_o - one-cycle completion pulse (reads and writes)
//   rdata_o - last completed read window, {mem[a+2], mem[a+1], mem[a]}
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_ADDR_SIZE = 16,
  parameter int DEPTH_LOG2    = 11,
  parameter int WAIT_CYCLES   = 0
) (
  input  logic                                      clk_i,
  input  logic                                      rstn_i,
  input  logic                                      req_i,
  input  logic                                      we_i,
  input  logic [MEM_ADDR_SIZE-1:0]                  addr_i,
  input  logic [BYTE_W-1:0]                         wdata_i,
  output logic                                      ready_o,
  output logic                                      valid_o,
  output logic [MEM_RESP_WINDOW_BYTES*BYTE_W-1:0]   rdata_o
);

  localparam int WIN_W = MEM_RESP_WINDOW_BYTES * BYTE_W;

  // Counter load value so WAIT lasts exactly WAIT_CYCLES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_resp_state_t         state_r;
  mem_resp_state_t         state_nx_s;
  logic [3:0]              cnt_r;
  logic [3:0]              cnt_nx_s;
  logic                    valid_r;
  logic [DEPTH_LOG2-1:0]   addr_r;
  logic                    we_r;
  logic [BYTE_W-1:0]       wdata_r;
  // Only bytes 0 and 1 are staged; byte 2 goes straight into rdata_r so the
  // output window changes in a single step at the end of RD2.
  logic [2*BYTE_W-1:0]     win_r;
  logic [WIN_W-1:0]        rdata_r;
  logic                    accept_s;
  logic                    ram_we_s;
  logic [DEPTH_LOG2-1:0]   raddr_s;
  logic [BYTE_W-1:0]       ram_rdata_s;
  logic                    unused_addr_s;

  // Upper CPU address bits only select a mirror of the RAM.
  assign unused_addr_s = ^addr_i[MEM_ADDR_SIZE-1:DEPTH_LOG2];

  assign accept_s = (state_r == IDLE) && req_i;
  assign ram_we_s = (state_r == WR);
  // Window byte address; DEPTH_LOG2-bit addition wraps 0x7FF -> 0x000.
  assign raddr_s  = addr_r + {{(DEPTH_LOG2-2){1'b0}}, window_offset(state_r)};

  assign ready_o  = (state_r == IDLE);
  assign valid_o  = valid_r;
  assign rdata_o  = rdata_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES > 0) begin
            state_nx_s = WAIT;
            cnt_nx_s   = WAIT_LOAD;
          end else begin
            state_nx_s = we_i ? WR : RD0;
            cnt_nx_s   = 4'd0;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nx_s = we_r ? WR : RD0;
        end else begin
          cnt_nx_s = cnt_r - 4'd1;
        end
      end
      RD0:     state_nx_s = RD1;
      RD1:     state_nx_s = RD2;
      RD2:     state_nx_s = DONE;
      WR:      state_nx_s = DONE;
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, wait counter and registered completion strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      valid_r <= (state_nx_s == DONE);
    end
  end

  // Request latch, window staging and output window register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_r  <= '0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      win_r   <= '0;
      rdata_r <= '0;
    end else begin
      if (accept_s) begin
        addr_r  <= addr_i[DEPTH_LOG2-1:0];
        we_r    <= we_i;
        wdata_r <= wdata_i;
      end
      case (state_r)
        RD0:     win_r[BYTE_W-1:0]        <= ram_rdata_s;
        RD1:     win_r[2*BYTE_W-1:BYTE_W] <= ram_rdata_s;
        RD2:     rdata_r                  <= {ram_rdata_s, win_r};
        default: ;
      endcase
    end
  end

  mem_responder_byte_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we_s),
    .waddr_i (addr_r),
    .wdata_i (wdata_r),
    .raddr_i (raddr_s),
    .rdata_o (ram_rdata_s)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed self-checking bench. u_dut0 runs with no wait
// states, u_dut3 with WAIT_CYCLES=3. Cycle 0 is the accept cycle; outputs
// are sampled on the falling clock edge.
module tb_mem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn0, req0, we0, ready0, valid0;
  logic [15:0] addr0;
  logic [7:0]  wdata0;
  logic [23:0] rdata0;
  logic        rstn3, req3, we3, ready3, valid3;
  logic [15:0] addr3;
  logic [7:0]  wdata3;
  logic [23:0] rdata3;

  int checks = 0;
  int errors = 0;

  mem_responder #(.MEM_ADDR_SIZE(16), .DEPTH_LOG2(11), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rstn_i(rstn0), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .ready_o(ready0), .valid_o(valid0), .rdata_o(rdata0));

  mem_responder #(.MEM_ADDR_SIZE(16), .DEPTH_LOG2(11), .WAIT_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rstn_i(rstn3), .req_i(req3), .we_i(we3), .addr_i(addr3),
    .wdata_i(wdata3), .ready_o(ready3), .valid_o(valid3), .rdata_o(rdata3));

  // Runs one transaction starting at the next falling edge. Returns the cycle
  // of valid (-1 if none within the bound), rdata in that cycle, the number of
  // busy cycles with ready high, and the number of busy cycles before valid in
  // which rdata differed from its value at accept.
  task automatic op(input bit sel, input bit we, input logic [15:0] addr,
                    input logic [7:0] wd, output int lat, output logic [23:0] rd,
                    output int rdy_bad, output int early_chg);
    logic [23:0] rd_before;
    lat = -1; rd = 24'h0; rdy_bad = 0; early_chg = 0;
    @(negedge clk);
    rd_before = sel ? rdata3 : rdata0;
    if (sel) begin req3 = 1'b1; we3 = we; addr3 = addr; wdata3 = wd; end
    else     begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    @(negedge clk);
    if (sel) req3 = 1'b0; else req0 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (sel ? ready3 : ready0) rdy_bad++;
      if (sel ? valid3 : valid0) begin
        lat = k;
        rd  = sel ? rdata3 : rdata0;
        break;
      end
      if ((sel ? rdata3 : rdata0) !== rd_before) early_chg++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn0 = 1'b0; rstn3 = 1'b0;
    #1;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %b exp 1", ready0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", valid0); end
    checks++; if (rdata0 !== 24'h000000) begin errors++; $display("FAIL reset_rdata0 got %h exp 000000", rdata0); end
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready3 got %b exp 1", ready3); end
    checks++; if (valid3 !== 1'b0) begin errors++; $display("FAIL reset_valid3 got %b exp 0", valid3); end
    checks++; if (rdata3 !== 24'h000000) begin errors++; $display("FAIL reset_rdata3 got %h exp 000000", rdata3); end
    @(negedge clk);
    rstn0 = 1'b1; rstn3 = 1'b1;
  endtask

  task automatic test_read_basic();
    int lat, rb, ec;
    logic [23:0] rd;
    op(1'b0, 1'b1, 16'h0010, 8'hA9, lat, rd, rb, ec);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency got %0d exp 2", lat); end
    op(1'b0, 1'b1, 16'h0011, 8'h42, lat, rd, rb, ec);
    op(1'b0, 1'b1, 16'h0012, 8'h00, lat, rd, rb, ec);
    checks++; if (rd !== 24'h000000) begin errors++; $display("FAIL wr_no_rdata got %h exp 000000", rd); end
    op(1'b0, 1'b0, 16'h0010, 8'h00, lat, rd, rb, ec);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got %0d exp 4", lat); end
    checks++; if (rd !== 24'h0042A9) begin errors++; $display("FAIL rd_window got %h exp 0042a9", rd); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL rd_ready_busy got %0d busy-ready cycles exp 0", rb); end
    checks++; if (ec !== 0) begin errors++; $display("FAIL rd_rdata_early got %0d early changes exp 0", ec); end
    @(negedge clk);
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL valid_one_cycle got %b exp 0", valid0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL ready_after_done got %b exp 1", ready0); end
  endtask

  task automatic test_wrap();
    int lat, rb, ec;
    logic [23:0] rd;
    op(1'b0, 1'b1, 16'h07FF, 8'h11, lat, rd, rb, ec);
    op(1'b0, 1'b1, 16'h0000, 8'h22, lat, rd, rb, ec);
    op(1'b0, 1'b1, 16'h0001, 8'h33, lat, rd, rb, ec);
    op(1'b0, 1'b0, 16'h07FF, 8'h00, lat, rd, rb, ec);
    checks++; if (rd !== 24'h332211) begin errors++; $display("FAIL wrap_window got %h exp 332211", rd); end
  endtask

  task automatic test_mirror();
    int lat, rb, ec;
    logic [23:0] rd;
    op(1'b0, 1'b1, 16'h0800, 8'h5A, lat, rd, rb, ec);
    op(1'b0, 1'b0, 16'h0000, 8'h00, lat, rd, rb, ec);
    checks++; if (rd[7:0] !== 8'h5A) begin errors++; $display("FAIL mirror_0000 got %h exp 5a", rd[7:0]); end
    op(1'b0, 1'b0, 16'h1800, 8'h00, lat, rd, rb, ec);
    checks++; if (rd[15:0] !== 16'h335A) begin errors++; $display("FAIL mirror_1800 got %h exp 335a", rd[15:0]); end
  endtask

  task automatic test_wait3();
    int lat, rb, ec, vcnt;
    logic [23:0] rd;
    op(1'b1, 1'b1, 16'h0010, 8'hC3, lat, rd, rb, ec);
    checks++; if (lat !== 5) begin errors++; $display("FAIL w3_wr_latency got %0d exp 5", lat); end
    op(1'b1, 1'b1, 16'h0011, 8'h3C, lat, rd, rb, ec);
    op(1'b1, 1'b1, 16'h0012, 8'h5A, lat, rd, rb, ec);
    op(1'b1, 1'b0, 16'h0010, 8'h00, lat, rd, rb, ec);
    checks++; if (lat !== 7) begin errors++; $display("FAIL w3_rd_latency got %0d exp 7", lat); end
    checks++; if (rd !== 24'h5A3CC3) begin errors++; $display("FAIL w3_rd_window got %h exp 5a3cc3", rd); end
    checks++; if (rb !== 0) begin errors++; $display("FAIL w3_ready_busy got %0d busy-ready cycles exp 0", rb); end
    // req held high for the whole transaction
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b0; addr3 = 16'h0011;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (valid3) begin lat = k; break; end
    end
    rd = rdata3;
    req3 = 1'b0;
    checks++; if (lat !== 7) begin errors++; $display("FAIL w3_held_latency got %0d exp 7", lat); end
    checks++; if (rd[15:0] !== 16'h5A3C) begin errors++; $display("FAIL w3_held_window got %h exp 5a3c", rd[15:0]); end
    vcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (valid3) vcnt++;
    end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL w3_held_extra got %0d pulses exp 0", vcnt); end
  endtask

  task automatic test_reset_mid();
    int lat, rb, ec, vcnt;
    logic [23:0] rd;
    // reset during RD1 of a read on u_dut0
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    rstn0 = 1'b0;
    #1;
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_rd1_valid got %b exp 0", valid0); end
    checks++; if (rdata0 !== 24'h000000) begin errors++; $display("FAIL rst_rd1_rdata got %h exp 000000", rdata0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL rst_rd1_ready got %b exp 1", ready0); end
    @(negedge clk);
    rstn0 = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (valid0) vcnt++;
    end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL rst_rd1_stale got %0d pulses exp 0", vcnt); end
    op(1'b0, 1'b0, 16'h0010, 8'h00, lat, rd, rb, ec);
    checks++; if (rd !== 24'h0042A9) begin errors++; $display("FAIL rst_rd1_reread got %h exp 0042a9", rd); end
    // reset during WAIT of a write on u_dut3
    op(1'b1, 1'b1, 16'h0020, 8'h01, lat, rd, rb, ec);
    @(negedge clk);
    req3 = 1'b1; we3 = 1'b1; addr3 = 16'h0020; wdata3 = 8'hFF;
    @(negedge clk);
    req3 = 1'b0;
    rstn3 = 1'b0;
    #1;
    checks++; if (ready3 !== 1'b1) begin errors++; $display("FAIL rst_wait_ready got %b exp 1", ready3); end
    @(negedge clk);
    rstn3 = 1'b1;
    op(1'b1, 1'b0, 16'h0020, 8'h00, lat, rd, rb, ec);
    checks++; if (rd[7:0] !== 8'h01) begin errors++; $display("FAIL rst_wait_nowrite got %h exp 01", rd[7:0]); end
  endtask

  task automatic test_back_to_back();
    int lat, rb, ec;
    logic [23:0] rd;
    op(1'b0, 1'b1, 16'h0030, 8'h77, lat, rd, rb, ec);
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_wr_latency got %0d exp 2", lat); end
    checks++; if (rd !== 24'h0042A9) begin errors++; $display("FAIL b2b_wr_rdata got %h exp 0042a9", rd); end
    checks++; if (ec !== 0) begin errors++; $display("FAIL b2b_wr_rdata_chg got %0d changes exp 0", ec); end
    op(1'b0, 1'b0, 16'h0030, 8'h00, lat, rd, rb, ec);
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_rd_latency got %0d exp 4", lat); end
    checks++; if (rd[7:0] !== 8'h77) begin errors++; $display("FAIL b2b_rd_data got %h exp 77", rd[7:0]); end
  endtask

  initial begin
    rstn0 = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 8'h0;
    rstn3 = 1'b1; req3 = 1'b0; we3 = 1'b0; addr3 = 16'h0; wdata3 = 8'h0;
    test_reset();
    test_read_basic();
    test_wrap();
    test_mirror();
    test_wait3();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
